// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester scheduler around one combinational 8-bit alu.
// One operation is accepted at a time over a valid/ready request channel.
// It executes from registered operands and is returned on a single
// valid/ready response channel, tagged with the requester ID.
// Build option: define ALU_ARB_FIXED_PRI_EN for fixed priority, where
// requester 0 always wins. Without it, arbitration is round-robin.

module alu (
  input  logic [7:0] op1_i,
  input  logic [7:0] op2_i,
  input  logic [2:0] operator_i,
  output logic [7:0] res_o,
  output logic       s_o,
  output logic       c_o,
  output logic       z_o,
  output logic       ov_o
);

  logic [8:0] wide;

  // Operator decode with carry/borrow and signed-overflow generation
  always_comb begin
    wide  = '0;
    res_o = '0;
    c_o   = 1'b0;
    ov_o  = 1'b0;
    unique case (operator_i)
      3'b000: begin
        wide  = {1'b0, op1_i} + {1'b0, op2_i};
        res_o = wide[7:0];
        c_o   = wide[8];
        ov_o  = (op1_i[7] == op2_i[7]) && (res_o[7] != op1_i[7]);
      end
      3'b001: begin
        wide  = {1'b0, op1_i} - {1'b0, op2_i};
        res_o = wide[7:0];
        c_o   = ~wide[8];
        ov_o  = (op1_i[7] != op2_i[7]) && (res_o[7] != op1_i[7]);
      end
      3'b010: res_o = op1_i & op2_i;
      3'b011: res_o = op1_i | op2_i;
      3'b100: res_o = op1_i ^ op2_i;
      3'b101: res_o = ~op1_i;
      3'b110: res_o = {op1_i[6:0], 1'b0};
      3'b111: res_o = {1'b0, op1_i[7:1]};
      default: res_o = '0;
    endcase
    s_o = res_o[7];
    z_o = (res_o == 8'h00);
  end

endmodule

module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_op1,
  input  logic [7:0] req0_op2,
  input  logic [2:0] req0_operator,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_op1,
  input  logic [7:0] req1_op2,
  input  logic [2:0] req1_operator,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_res,
  output logic       rsp_s,
  output logic       rsp_c,
  output logic       rsp_z,
  output logic       rsp_ov,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;

  logic       grant0, grant1, accept;

  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic [2:0] opr_q, opr_d;
  logic       id_q, id_d;

  logic [7:0] res_q, res_d;
  logic       s_q, s_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       ov_q, ov_d;
  logic       rid_q, rid_d;

  logic [7:0] alu_res;
  logic       alu_s, alu_c, alu_z, alu_ov;

`ifndef ALU_ARB_FIXED_PRI_EN
  logic       last_q, last_d;
`endif

  // Request arbitration: grants only in IDLE, never dependent on rsp_ready
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`else
      grant0 = req0_valid & (~req1_valid |  last_q);
      grant1 = req1_valid & (~req0_valid | ~last_q);
`endif
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture from the winning requester on acceptance
  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    opr_d = opr_q;
    id_d  = id_q;
    if (grant0) begin
      op1_d = req0_op1;
      op2_d = req0_op2;
      opr_d = req0_operator;
      id_d  = 1'b0;
    end else if (grant1) begin
      op1_d = req1_op1;
      op2_d = req1_op2;
      opr_d = req1_operator;
      id_d  = 1'b1;
    end
  end

  // Operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      opr_q <= '0;
      id_q  <= 1'b0;
    end else begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      opr_q <= opr_d;
      id_q  <= id_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRI_EN
  // Round-robin pointer follows the most recent grant
  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = 1'b0;
    end else if (grant1) begin
      last_d = 1'b1;
    end
  end

  // Pointer register; resets to 1 so requester 0 wins first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  alu u_alu (
    .op1_i      (op1_q),
    .op2_i      (op2_q),
    .operator_i (opr_q),
    .res_o      (alu_res),
    .s_o        (alu_s),
    .c_o        (alu_c),
    .z_o        (alu_z),
    .ov_o       (alu_ov)
  );

  // Response capture at the end of EXEC; held unchanged through RESP
  always_comb begin
    res_d = res_q;
    s_d   = s_q;
    c_d   = c_q;
    z_d   = z_q;
    ov_d  = ov_q;
    rid_d = rid_q;
    if (state_q == EXEC) begin
      res_d = alu_res;
      s_d   = alu_s;
      c_d   = alu_c;
      z_d   = alu_z;
      ov_d  = alu_ov;
      rid_d = id_q;
    end
  end

  // Response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      s_q   <= 1'b0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      ov_q  <= 1'b0;
      rid_q <= 1'b0;
    end else begin
      res_q <= res_d;
      s_q   <= s_d;
      c_q   <= c_d;
      z_q   <= z_d;
      ov_q  <= ov_d;
      rid_q <= rid_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rid_q;
  assign rsp_res   = res_q;
  assign rsp_s     = s_q;
  assign rsp_c     = c_q;
  assign rsp_z     = z_q;
  assign rsp_ov    = ov_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a cycle model predicts grants and
// state, and pushes expected responses to a scoreboard queue on acceptance.
// The monitor pops the queue and compares when the DUT presents a response.
// Honours ALU_ARB_FIXED_PRI_EN the same way as the design.

module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0] req0_operator, req1_operator;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_res;
  logic       rsp_s, rsp_c, rsp_z, rsp_ov, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [12:0] sb_q[$];
  bit          id_log[$];
  int unsigned rsp_count = 0;
  logic [12:0] last_rsp = '0;

  int          m_state = 0;
  bit          m_last  = 1'b1;

  alu_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op1      (req0_op1),
    .req0_op2      (req0_op2),
    .req0_operator (req0_operator),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op1      (req1_op1),
    .req1_op2      (req1_op2),
    .req1_operator (req1_operator),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_res       (rsp_res),
    .rsp_s         (rsp_s),
    .rsp_c         (rsp_c),
    .rsp_z         (rsp_z),
    .rsp_ov        (rsp_ov),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {id, res, s, c, z, ov} from the documented alu flag rules
  function automatic logic [12:0] model(input bit id, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, ov;
    w = '0; r = '0; c = 1'b0; ov = 1'b0;
    case (op)
      3'd0: begin w = a + b; r = w[7:0]; c = w[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = ~w[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = {a[6:0], 1'b0};
      default: r = {1'b0, a[7:1]};
    endcase
    return {id, r, r[7], c, (r == 8'h00), ov};
  endfunction

  // Monitor and cycle model, sampled on the falling edge
  always @(negedge clk) begin
    bit e0, e1;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp", {rsp_id, rsp_res, rsp_s, rsp_c, rsp_z, rsp_ov}, 0);
      m_state = 0;
      m_last  = 1'b1;
      sb_q.delete();
    end else begin
`ifdef ALU_ARB_FIXED_PRI_EN
      e0 = (m_state == 0) && req0_valid;
      e1 = (m_state == 0) && req1_valid && !req0_valid;
`else
      e0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
      e1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
`endif
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("busy", busy, m_state != 0);
      check("rsp_valid", rsp_valid, m_state == 2);
      case (m_state)
        0: begin
          if (e0) begin
            sb_q.push_back(model(1'b0, req0_op1, req0_op2, req0_operator));
            m_last = 1'b0; m_state = 1;
          end else if (e1) begin
            sb_q.push_back(model(1'b1, req1_op1, req1_op2, req1_operator));
            m_last = 1'b1; m_state = 1;
          end
        end
        1: m_state = 2;
        default: begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
          end else begin
            check("rsp_id", rsp_id, sb_q[0][12]);
            check("rsp_data", {rsp_res, rsp_s, rsp_c, rsp_z, rsp_ov}, sb_q[0][11:0]);
            if (rsp_ready) begin
              last_rsp = {rsp_id, rsp_res, rsp_s, rsp_c, rsp_z, rsp_ov};
              id_log.push_back(rsp_id);
              void'(sb_q.pop_front());
              rsp_count++;
              m_state = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    if (id == 1'b0) begin
      req0_op1 = a; req0_op2 = b; req0_operator = op; req0_valid = 1'b1;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_operator = op; req1_valid = 1'b1;
    end
  endtask

  // Hold valid until the requester sees ready, then drop it after the edge
  task automatic wait_accept(input bit id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    cyc();
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    drive(id, a, b, op);
    wait_accept(id);
  endtask

  task automatic wait_rsp(input int unsigned target);
    for (int i = 0; i < 60; i++) begin
      if (rsp_count >= target) break;
      cyc();
    end
    if (rsp_count < target) check("rsp_timeout", rsp_count, target);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned base, lbase;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_operator = '0;
    req1_op1 = '0; req1_op2 = '0; req1_operator = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single request: 0x7F + 0x01
    issue(1'b0, 8'h7F, 8'h01, 3'd0);
    wait_rsp(1);
    check("add_7f_01", last_rsp, {1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1});

    // Continuous contention after reset
    do_reset();
    base = rsp_count; lbase = id_log.size();
    drive(1'b0, 8'h05, 8'h05, 3'd1);
    drive(1'b1, 8'hF0, 8'h0F, 3'd4);
    wait_rsp(base + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      check("contend_id", id_log[lbase + k], 0);
`else
      check("contend_id", id_log[lbase + k], k % 2);
`endif
    end
    cyc(); cyc();

    // Backpressure: response held for 5 cycles, other requester waiting
    rsp_ready = 1'b0;
    base = rsp_count;
    issue(1'b0, 8'hFF, 8'h01, 3'd0);
    drive(1'b1, 8'h3C, 8'h0F, 3'd2);
    repeat (6) cyc();
    check("bp_no_pop", rsp_count, base);
    rsp_ready = 1'b1;
    wait_rsp(base + 1);
    check("add_ff_01", last_rsp, {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    wait_accept(1'b1);
    wait_rsp(base + 2);
    check("and_3c_0f", last_rsp, {1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0});

    // Operand change right after acceptance
    base = rsp_count;
    issue(1'b0, 8'h81, 8'h01, 3'd6);
    req0_op1 = 8'h00;
    wait_rsp(base + 1);
    check("lsl_81", last_rsp, {1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset during EXEC drops the operation
    base = rsp_count; lbase = id_log.size();
    issue(1'b1, 8'h12, 8'h34, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_rsp_valid", rsp_valid, 0);
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 8'h0A, 8'h03, 3'd1);
    drive(1'b1, 8'h0A, 8'h03, 3'd3);
    @(negedge clk);
    check("rst_grant0", req0_ready, 1);
    check("rst_grant1", req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    wait_accept(1'b1);
    wait_rsp(base + 2);
    repeat (4) cyc();
    check("no_extra_rsp", rsp_count, base + 2);
    check("post_rst_id0", id_log[lbase], 0);
    check("post_rst_id1", id_log[lbase + 1], 1);

    // NOT then LSR
    base = rsp_count;
    issue(1'b1, 8'h00, 8'h00, 3'd5);
    wait_rsp(base + 1);
    check("not_00", last_rsp, {1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    issue(1'b0, 8'h01, 8'h01, 3'd7);
    wait_rsp(base + 2);
    check("lsr_01", last_rsp, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // A few random operations through both requesters
    for (int n = 0; n < 8; n++) begin
      base = rsp_count;
      issue(1'(n % 2), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      wait_rsp(base + 1);
    end

    cyc(); cyc();
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester scheduler that shares one instance of the team's combinational 8-bit `alu` between two client blocks. It accepts one operation at a time over a valid/ready request channel and registers the operands. It then registers the ALU result and flags, and returns them over a single valid/ready response channel tagged with the requester ID. It sits between the two datapath clients and the ALU, and owns all sequencing of that ALU.

## Interface
Parameters:
- None. Data width is fixed at 8 bits and the operator code at 3 bits, matching `alu`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid`, `req1_valid` in 1 each: request present from requester 0 / 1.
- `req0_ready`, `req1_ready` out 1 each: request accepted this cycle (combinational).
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2` in 8 each: operands.
- `req0_operator`, `req1_operator` in 3 each: ALU operator code.
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LSL, 111 LSR.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer takes response.
- `rsp_id` out 1: requester that issued the response.
- `rsp_res` out 8: result.
- `rsp_s`, `rsp_c`, `rsp_z`, `rsp_ov` out 1 each: sign, carry/borrow, zero, overflow.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among asserted `reqX_valid`. The winner's `reqX_ready` = 1 in the same cycle; the loser's ready stays 0.
  - On the edge, latch the winner's op1/op2/operator and its ID, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The `alu` is driven only from the latched operand registers.
  - On the edge, capture res, s, c, z, ov into the response registers and go to RESP.
- RESP:
  - `rsp_valid` = 1; all `rsp_*` outputs are stable.
  - On `rsp_ready` = 1, go to IDLE. Otherwise hold indefinitely.
- Both `reqX_ready` are 0 outside IDLE. Requesters must hold valid and payload until they see ready.
- Round-robin arbitration (default build):
  - A pointer `last` records the ID of the most recent grant.
  - When both requesters are valid, the one ≠ `last` wins.
  - When one is valid, it wins.
  - `last` updates only on an accepted request.
- Flag semantics are exactly those of `alu`:
  - ADD: c = carry out.
  - SUB: c = inverted bit 8 of the 9-bit difference.
  - Logic and shift operators: c = 0, ov = 0.
  - z = (res == 0); s = res[7].
- Reset (any time, including mid-transaction):
  - Outputs: `rsp_valid`=0, `busy`=0, `rsp_res`=0x00, all flags 0, `rsp_id`=0.
  - Internal: state=IDLE, `last`=1, so requester 0 wins the first contention.
  - An in-flight operation is discarded; no response is produced for it.

## Timing
- Acceptance happens in cycle A (IDLE, valid & ready).
- Cycle A+1: EXEC.
- Cycle A+2: `rsp_valid` = 1 at the earliest.
- If `rsp_ready` = 1 in A+2, the state is IDLE in A+3, and the next request can be accepted in A+3.
- Peak throughput is one operation per 3 cycles.
- Backpressure: each cycle `rsp_ready` is held low extends RESP by one cycle. Response data does not change while `rsp_valid`=1.
- Request inputs that change after acceptance do not affect the in-flight result.
- `reqX_ready` depends combinationally on `reqX_valid` and state. It never depends on `rsp_ready`.

## Configuration
- `ALU_ARB_FIXED_PRI_EN` defined: fixed priority.
  - Requester 0 always wins when both are valid.
  - `last` is not implemented and is not used.
- Not defined: round-robin as described in Operation.
- The macro has no other effect on timing or the interface.

## Test plan
- Reset release, then req0 alone with op1=0x7F, op2=0x01, ADD:
  - `req0_ready` = 1 in cycle A.
  - Cycle A+2: `rsp_valid`=1, id=0, res=0x80, s=1, c=0, z=0, ov=1.
- Both requesters valid and held continuously after reset (req0 SUB 0x05-0x05, req1 XOR 0xF0^0x0F), `rsp_ready`=1:
  - Round-robin build: responses alternate id 0,1,0,1.
    - id 0: res=0x00, z=1, c=1.
    - id 1: res=0xFF, s=1.
  - Fixed-priority build: only id 0 is ever served.
- Response backpressure: ADD 0xFF+0x01, `rsp_ready` low for 5 cycles:
  - `rsp_valid` and res=0x00, c=1, z=1 are held stable for all 5 cycles.
  - `req0_ready`/`req1_ready` stay 0 throughout.
  - IDLE is reached one cycle after `rsp_ready` rises.
- Operand change after acceptance: LSL 0x81 accepted, then op1 changes to 0x00 in A+1:
  - Response is res=0x02, c=0, s=0.
- `rst_n` pulsed low during EXEC:
  - `busy` and `rsp_valid` go to 0 immediately (asynchronous).
  - No response appears for the dropped operation.
  - The next contention after reset grants requester 0.
- NOT 0x00, then LSR 0x01:
  - First response: res=0xFF, s=1, ov=0.
  - Second response: res=0x00, z=1, c=0.
